// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared types and constants for the FIFO read-side stream
//               consumer (skid buffer occupancy encoding, stats width).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Width of the optional statistics counters.
    localparam int STATS_W = 32;

endpackage
`default_nettype wire

// File: rtl/stream_skid2.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid2
// Description : 2-entry skid register (head + spare). Outputs come only from
//               the head register, so nothing on the push side reaches the
//               outputs combinationally.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               push/push_data - write one entry (ignored when full)
//               pop            - consume the head entry (ignored when empty)
//               clr            - synchronous discard of both entries
//               head_data      - current head entry
//               valid          - head entry holds a word
//               full           - both entries occupied
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid2
    import fifo_rd_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         clr,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic         full
);

    buf_state_t   r_state;
    buf_state_t   w_state_nxt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_spare;
    logic [W-1:0] w_head_nxt;
    logic [W-1:0] w_spare_nxt;
    logic         w_pop;

    // A pop only means something when the head actually holds a word.
    assign w_pop = pop && (r_state != BUF_EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_head  <= '0;
            r_spare <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_spare <= w_spare_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_spare_nxt = r_spare;
        if (clr) begin
            // Clear dominates both push and pop; stale data is left in place
            // because valid masks it.
            w_state_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (push) begin
                        w_head_nxt  = push_data;
                        w_state_nxt = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && w_pop) begin
                        // Steady streaming: new word goes straight to head.
                        w_head_nxt = push_data;
                    end else if (push) begin
                        w_spare_nxt = push_data;
                        w_state_nxt = BUF_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        w_head_nxt  = r_spare;
                        w_state_nxt = BUF_ONE;
                    end
                end
                default: begin
                    w_state_nxt = BUF_EMPTY;
                end
            endcase
        end
    end

    assign head_data = r_head;
    assign valid     = (r_state != BUF_EMPTY);
    assign full      = (r_state == BUF_TWO);

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side consumer for the dual-clock Gray-pointer FIFO.
//               Pops words via rinc/rempty/rdata and presents them as a
//               registered valid/ready stream with a last marker every
//               BURST_LEN beats. One word per rclk in steady state.
// Ports       : rclk, rrst      - read clock, asynchronous active-high reset
//               fifo_rdata      - FIFO read data (valid when !fifo_rempty)
//               fifo_rempty     - FIFO empty flag
//               fifo_rinc       - FIFO pop strobe
//               flush           - synchronous discard of buffer + burst position
//               m_data/m_valid/m_last/m_ready - downstream stream
//               beats_out, stall_cycles - optional statistics
// Options     : FIFO_RD_STREAM_STATS_EN adds beats_out (handshake count,
//               wrapping) and stall_cycles (valid && !ready cycles,
//               saturating); both cleared by flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic [DSIZE-1:0]   fifo_rdata,
    input  logic               fifo_rempty,
    output logic               fifo_rinc,
    input  logic               flush,
    output logic [DSIZE-1:0]   m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [STATS_W-1:0] beats_out,
    output logic [STATS_W-1:0] stall_cycles
`endif
);

    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] c_last_beat = BCW'(BURST_LEN - 1);

    logic [BCW-1:0] r_beat_cnt;
    logic           w_tag;
    logic           w_full;
    logic           w_valid;
    logic           w_hs;
    logic [DSIZE:0] w_head;

    // Pop strobe never looks at m_ready, keeping the downstream ready off the
    // FIFO pointer path. The spare entry absorbs the word popped in the cycle
    // a stall begins.
    assign fifo_rinc = !fifo_rempty && !w_full && !flush && !rrst;

    // Burst position is counted at the push side, so the tag travels with
    // the word through the skid buffer.
    assign w_tag = (r_beat_cnt == c_last_beat);
    assign w_hs  = w_valid && m_ready;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_beat_cnt <= '0;
        end else if (flush) begin
            r_beat_cnt <= '0;
        end else if (fifo_rinc) begin
            r_beat_cnt <= w_tag ? '0 : r_beat_cnt + BCW'(1);
        end
    end

    stream_skid2 #(
        .W (DSIZE + 1)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (fifo_rinc),
        .push_data ({fifo_rdata, w_tag}),
        .pop       (w_hs),
        .clr       (flush),
        .head_data (w_head),
        .valid     (w_valid),
        .full      (w_full)
    );

    assign m_data  = w_head[DSIZE:1];
    assign m_valid = w_valid;
    assign m_last  = w_head[0] && w_valid;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STATS_W-1:0] r_beats;
    logic [STATS_W-1:0] r_stalls;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_beats  <= '0;
            r_stalls <= '0;
        end else if (flush) begin
            r_beats  <= '0;
            r_stalls <= '0;
        end else begin
            if (w_hs) begin
                r_beats <= r_beats + STATS_W'(1);
            end
            if (w_valid && !m_ready && (r_stalls != '1)) begin
                r_stalls <= r_stalls + STATS_W'(1);
            end
        end
    end

    assign beats_out    = r_beats;
    assign stall_cycles = r_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream: directed vector
//               table, mid-operation reset, randomized traffic against a
//               queue-based reference model, optional stats checks
//               (FIFO_RD_STREAM_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DSIZE     = 8;
    localparam int BURST_LEN = 4;
    localparam int NVEC      = 28;

    logic             rclk;
    logic             rrst;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic             flush;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]      beats_out;
    logic [31:0]      stall_cycles;
`endif

    fifo_rd_stream #(
        .DSIZE     (DSIZE),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .flush       (flush),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beats_out    (beats_out),
        .stall_cycles (stall_cycles)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    typedef struct {
        logic             rempty;
        logic [DSIZE-1:0] rdata;
        logic             ready;
        logic             fl;
        logic             e_rinc;
        logic             e_valid;
        logic [DSIZE-1:0] e_data;
        logic             e_last;
    } vec_t;

    function automatic vec_t mk(input logic re, input logic [7:0] rd, input logic rdy,
                                input logic fl, input logic er, input logic ev,
                                input logic [7:0] ed, input logic el);
        vec_t v;
        v.rempty = re; v.rdata = rd; v.ready = rdy; v.fl = fl;
        v.e_rinc = er; v.e_valid = ev; v.e_data = ed; v.e_last = el;
        return v;
    endfunction

    typedef struct packed {
        logic [DSIZE-1:0] d;
        logic             l;
    } beat_t;

    vec_t             tbl [NVEC];
    logic [DSIZE-1:0] fq[$];      // words sitting in the upstream FIFO
    beat_t            eq[$];      // model of words held by the consumer
    int               pcnt;       // words popped since reset/flush, mod BURST_LEN
    int unsigned      mbeats;
    int unsigned      mstalls;

    initial begin
        // Streaming 01..08, stall, flush (rempty, rdata, ready, flush | rinc, valid, data, last)
        tbl[0]  = mk(0, 8'h01, 1, 0, 1, 0, 8'h00, 0);
        tbl[1]  = mk(0, 8'h02, 1, 0, 1, 1, 8'h01, 0);
        tbl[2]  = mk(0, 8'h03, 1, 0, 1, 1, 8'h02, 0);
        tbl[3]  = mk(0, 8'h04, 1, 0, 1, 1, 8'h03, 0);
        tbl[4]  = mk(0, 8'h05, 1, 0, 1, 1, 8'h04, 1);
        tbl[5]  = mk(0, 8'h06, 1, 0, 1, 1, 8'h05, 0);
        tbl[6]  = mk(0, 8'h07, 1, 0, 1, 1, 8'h06, 0);
        tbl[7]  = mk(0, 8'h08, 1, 0, 1, 1, 8'h07, 0);
        tbl[8]  = mk(1, 8'h00, 1, 0, 0, 1, 8'h08, 1);
        tbl[9]  = mk(1, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[10] = mk(0, 8'h11, 1, 0, 1, 0, 8'h00, 0);
        tbl[11] = mk(0, 8'h12, 0, 0, 1, 1, 8'h11, 0);
        tbl[12] = mk(0, 8'h13, 0, 0, 0, 1, 8'h11, 0);
        tbl[13] = mk(0, 8'h13, 0, 0, 0, 1, 8'h11, 0);
        tbl[14] = mk(0, 8'h13, 1, 0, 0, 1, 8'h11, 0);
        tbl[15] = mk(0, 8'h13, 1, 0, 1, 1, 8'h12, 0);
        tbl[16] = mk(0, 8'h14, 1, 0, 1, 1, 8'h13, 0);
        tbl[17] = mk(1, 8'h00, 1, 0, 0, 1, 8'h14, 1);
        tbl[18] = mk(1, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[19] = mk(0, 8'h21, 0, 0, 1, 0, 8'h00, 0);
        tbl[20] = mk(0, 8'h22, 0, 0, 1, 1, 8'h21, 0);
        tbl[21] = mk(0, 8'h23, 0, 1, 0, 1, 8'h21, 0);
        tbl[22] = mk(0, 8'h23, 1, 0, 1, 0, 8'h00, 0);
        tbl[23] = mk(0, 8'h24, 1, 0, 1, 1, 8'h23, 0);
        tbl[24] = mk(0, 8'h25, 1, 0, 1, 1, 8'h24, 0);
        tbl[25] = mk(0, 8'h26, 1, 0, 1, 1, 8'h25, 0);
        tbl[26] = mk(1, 8'h00, 1, 0, 0, 1, 8'h26, 1);
        tbl[27] = mk(1, 8'h00, 1, 0, 0, 0, 8'h00, 0);

        // ---- reset with a non-empty FIFO ----
        rrst = 1'b1; fifo_rempty = 1'b0; fifo_rdata = 8'hAA; flush = 1'b0; m_ready = 1'b1;
        tick(); tick();
        chk("rst_rinc",  {31'd0, fifo_rinc}, 0);
        chk("rst_valid", {31'd0, m_valid},   0);
        chk("rst_last",  {31'd0, m_last},    0);
        chk("rst_data",  {24'd0, m_data},    0);
`ifdef FIFO_RD_STREAM_STATS_EN
        chk("rst_beats",  beats_out,    0);
        chk("rst_stalls", stall_cycles, 0);
`endif
        rrst = 1'b0;

        // ---- directed vector table ----
        for (int i = 0; i < NVEC; i++) begin
            fifo_rempty = tbl[i].rempty;
            fifo_rdata  = tbl[i].rdata;
            m_ready     = tbl[i].ready;
            flush       = tbl[i].fl;
            @(negedge rclk);
            chk($sformatf("vec%0d_rinc", i),  {31'd0, fifo_rinc}, {31'd0, tbl[i].e_rinc});
            chk($sformatf("vec%0d_valid", i), {31'd0, m_valid},   {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_last", i),  {31'd0, m_last},    {31'd0, tbl[i].e_last});
            if (tbl[i].e_valid)
                chk($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, tbl[i].e_data});
            tick();
        end
        flush = 1'b0;

        // ---- reset mid-operation: two words buffered, then async reset ----
        fifo_rempty = 1'b0; fifo_rdata = 8'h31; m_ready = 1'b0;
        tick();
        fifo_rdata = 8'h32;
        tick();
        fifo_rempty = 1'b1;
        #2;
        chk("mid_pre_valid", {31'd0, m_valid}, 1);
        chk("mid_pre_data",  {24'd0, m_data},  32'h31);
        rrst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid},   0);
        chk("mid_rst_rinc",  {31'd0, fifo_rinc}, 0);
        chk("mid_rst_data",  {24'd0, m_data},    0);
        tick();
        rrst = 1'b0;

        // ---- randomized traffic against the reference model ----
        pcnt = 0; mbeats = 0; mstalls = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic e_valid, e_rinc, hs;
            while (fq.size() < 4) fq.push_back(DSIZE'($urandom));
            if (cyc < 200) begin
                // alternating empty flag
                fifo_rempty = cyc[0];
                flush       = 1'b0;
                m_ready     = ($urandom_range(0, 3) != 0);
            end else begin
                fifo_rempty = ($urandom_range(0, 3) == 0);
                flush       = ($urandom_range(0, 15) == 0);
                m_ready     = (cyc < 800) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) != 0;
            end
            fifo_rdata = fq[0];
            @(negedge rclk);
            e_valid = (eq.size() != 0);
            e_rinc  = !fifo_rempty && (eq.size() < 2) && !flush;
            chk("rnd_valid", {31'd0, m_valid},   {31'd0, e_valid});
            chk("rnd_rinc",  {31'd0, fifo_rinc}, {31'd0, e_rinc});
            if (e_valid) begin
                chk("rnd_data", {24'd0, m_data}, {24'd0, eq[0].d});
                chk("rnd_last", {31'd0, m_last}, {31'd0, eq[0].l});
            end
`ifdef FIFO_RD_STREAM_STATS_EN
            chk("rnd_beats",  beats_out,    mbeats);
            chk("rnd_stalls", stall_cycles, mstalls);
`endif
            // model update for the coming edge: handshake first, then flush or push
            hs = e_valid && m_ready;
            if (hs) void'(eq.pop_front());
            if (flush) begin
                eq.delete();
                pcnt = 0; mbeats = 0; mstalls = 0;
            end else begin
                if (e_rinc) begin
                    beat_t b;
                    b.d = fq.pop_front();
                    b.l = (pcnt == BURST_LEN - 1);
                    eq.push_back(b);
                    pcnt = (pcnt + 1) % BURST_LEN;
                end
                if (hs) mbeats++;
                if (e_valid && !m_ready && mstalls != 32'hFFFF_FFFF) mstalls++;
            end
            tick();
        end

        // ---- stats: 10 beats with 3 stall cycles, then flush ----
        flush = 1'b1; fifo_rempty = 1'b1; m_ready = 1'b0;
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'd0, m_valid}, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
        fifo_rempty = 1'b0;
        for (int c = 0; c < 14; c++) begin
            fifo_rdata = DSIZE'(c + 8'h40);
            m_ready    = !(c == 3 || c == 4 || c == 9);
            tick();
        end
        fifo_rempty = 1'b1; m_ready = 1'b0;
        @(negedge rclk);
        chk("st_beats",  beats_out,    10);
        chk("st_stalls", stall_cycles, 3);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_fl_beats",  beats_out,    0);
        chk("st_fl_stalls", stall_cycles, 0);
        chk("st_fl_valid",  {31'd0, m_valid}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
